// File: rtl/operation_s_chunked_pkg.sv
// Shared definitions for the chunked successor operation.
//   state_e        : IDLE / RUN controller state
//   nchunk()       : number of CHUNK-wide slices in a BW-wide operand
//   idx_w()        : width of the chunk index (never less than 1 bit)
//   chunk_cfg_ok() : legality check for the (BW, CHUNK) pair
package op_pkg;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  function automatic int nchunk(input int bw, input int chunk);
    return bw / chunk;
  endfunction

  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic bit chunk_cfg_ok(input int bw, input int chunk);
    return (chunk >= 1) && (bw >= chunk) && ((bw % chunk) == 0);
  endfunction

endpackage

// File: rtl/operation_s_chunked_add.sv
// Combinational CHUNK-bit incrementer slice: {co, s} = a + ci.
//   a  : operand chunk
//   ci : carry in
//   s  : sum chunk
//   co : carry out
module s_chunk_add #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co
);

  assign {co, s} = {1'b0, a} + {{CHUNK{1'b0}}, ci};

endmodule

// File: rtl/operation_s_chunked.sv
// Successor operation RES = IN + 1 with the carry walked CHUNK bits per clock.
//   CLK : clock (posedge)
//   RST : synchronous active-high reset
//   ST  : start; a 0->1 edge while idle launches an operation
//   IN  : operand, captured on the start edge
//   RD  : 1 = idle with RES valid, 0 = busy
//   RES : result, updated only on completion or reset
//   OVF : last completed operation overflowed (IN was all-ones)
module operation_s_chunked
  import op_pkg::*;
#(
  parameter int BW    = 16,
  parameter int CHUNK = 4,
  parameter int EARLY = 1,
  parameter int SAT   = 0
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          ST,
  input  logic [BW-1:0] IN,
  output logic          RD,
  output logic [BW-1:0] RES,
  output logic          OVF
);

  localparam int NCHUNK = nchunk(BW, CHUNK);
  localparam int KW     = idx_w(NCHUNK);

  if (!chunk_cfg_ok(BW, CHUNK)) begin : g_bad_cfg
    $error("operation_s_chunked: CHUNK must be >= 1 and divide BW");
  end

  state_e          state_q, state_d;
  logic            st_old_q;
  logic [BW-1:0]   op_q, op_d;
  logic [BW-1:0]   w_q, w_d;
  logic            c_q, c_d;
  logic [KW-1:0]   k_q, k_d;
  logic            rd_q, rd_d;
  logic [BW-1:0]   res_q, res_d;
  logic            ovf_q, ovf_d;

  logic             start;
  logic [CHUNK-1:0] chunk_a, chunk_s;
  logic             chunk_co;
  logic             done;
  logic [BW-1:0]    w_upd;

  assign start   = ST & ~st_old_q;
  assign chunk_a = op_q[int'(k_q)*CHUNK +: CHUNK];

  s_chunk_add #(.CHUNK(CHUNK)) u_add (
    .a  (chunk_a),
    .ci (c_q),
    .s  (chunk_s),
    .co (chunk_co)
  );

  // Once the carry dies every higher chunk of W already equals OP, so the
  // result is final as soon as co drops (when EARLY is enabled).
  assign done = (k_q == KW'(NCHUNK - 1)) || ((EARLY != 0) && !chunk_co);

  always_comb begin
    w_upd = w_q;
    w_upd[int'(k_q)*CHUNK +: CHUNK] = chunk_s;
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    w_d     = w_q;
    c_d     = c_q;
    k_d     = k_q;
    rd_d    = rd_q;
    res_d   = res_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d    = IN;
          w_d     = IN;
          c_d     = 1'b1;
          k_d     = '0;
          rd_d    = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        // Edges on ST are deliberately not looked at here: no queuing.
        w_d = w_upd;
        c_d = chunk_co;
        k_d = k_q + KW'(1);
        if (done) begin
          res_d   = ((SAT != 0) && chunk_co) ? '1 : w_upd;
          ovf_d   = chunk_co;
          rd_d    = 1'b1;
          k_d     = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    st_old_q <= ST;  // tracked through reset so a held ST never fires on release
    if (RST) begin
      state_q <= IDLE;
      op_q    <= '0;
      w_q     <= '0;
      c_q     <= 1'b0;
      k_q     <= '0;
      rd_q    <= 1'b1;
      res_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      w_q     <= w_d;
      c_q     <= c_d;
      k_q     <= k_d;
      rd_q    <= rd_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
    end
  end

  assign RD  = rd_q;
  assign RES = res_q;
  assign OVF = ovf_q;

endmodule
